data_matrix_mem_access: RTL and testbench



---
 rtl/data_matrix_mem_access.sv | 157 +++++++++++++++
 tb/tb_data_matrix_mem_access.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/data_matrix_mem_access.sv
// LC-3 data matrix memory access: MAR/MDR registers and the memory handshake FSM.
// Define MEM_TIMEOUT_EN to add a bounded wait with a sticky mem_err flag.
module data_matrix_mem_access #(
    parameter int          MEM_LAT_MAX = 16,
    parameter logic [15:0] ERR_DATA    = 16'hDEAD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc,
    input  logic [15:0] ea,
    input  logic [15:0] bus,
    input  logic        ld_mar,
    input  logic [1:0]  mar_sel,
    input  logic        ld_mdr,
    input  logic        mem_en,
    input  logic        r_w,
    output logic [15:0] mar,
    output logic [15:0] mdr,
    output logic        r,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic        we_q;
    logic        start;
    logic        mar_open;
    logic        rd_done;
    logic        to_hit;
    logic [15:0] mar_src;

    // A new access may start in DONE too, giving back-to-back 2-cycle accesses.
    assign start    = mem_en && (state != REQ);
    assign mar_open = (state != REQ);
    assign rd_done  = (state == REQ) && mem_ready && !we_q;

`ifdef MEM_TIMEOUT_EN
    localparam logic [15:0] LAT_LAST = 16'(MEM_LAT_MAX - 1);

    logic [15:0] wait_cnt;
    logic        err_q;

    assign to_hit = (state == REQ) && !mem_ready && (wait_cnt == LAT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state != REQ) begin
            wait_cnt <= '0;
        end else if (!mem_ready) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (to_hit) begin
            err_q <= 1'b1;
        end
    end

    assign mem_err = err_q;
`else
    assign to_hit  = 1'b0;
    assign mem_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (mem_en) begin
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (mem_ready || to_hit) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = mem_en ? REQ : IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q <= 1'b0;
        end else if (start) begin
            we_q <= r_w;
        end
    end

    always_comb begin
        mar_src = bus;
        unique case (1'b1)
            (mar_sel == 2'b00): mar_src = pc;
            (mar_sel == 2'b01): mar_src = ea;
            mar_sel[1]:         mar_src = bus;
            default:            mar_src = bus;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mar <= '0;
        end else if (ld_mar && mar_open) begin
            mar <= mar_src;
        end
    end

    // Read return data has priority; ld_mdr only lands while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mdr <= '0;
        end else if (rd_done) begin
            mdr <= mem_rdata;
        end else if (to_hit && !we_q) begin
            mdr <= ERR_DATA;
        end else if (ld_mdr && (state == IDLE)) begin
            mdr <= bus;
        end
    end

    assign busy      = (state != IDLE);
    assign r         = (state == DONE);
    assign mem_req   = (state == REQ);
    assign mem_we    = (state == REQ) && we_q;
    assign mem_addr  = mar;
    assign mem_wdata = mdr;

endmodule

// File: tb/tb_data_matrix_mem_access.sv
// Directed bench for data_matrix_mem_access; checks use immediate assertions.
// Build with MEM_TIMEOUT_EN defined to also exercise the timeout path.
module tb_data_matrix_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc, ea, bus;
    logic        ld_mar, ld_mdr, mem_en, r_w;
    logic [1:0]  mar_sel;
    logic [15:0] mar, mdr, mem_addr, mem_wdata, mem_rdata;
    logic        r, busy, mem_req, mem_we, mem_ready, mem_err;

    int checks = 0;
    int errors = 0;
    int r_cnt  = 0;

    always #5 clk = ~clk;

    data_matrix_mem_access #(
        .MEM_LAT_MAX(4),
        .ERR_DATA   (16'hDEAD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pc       (pc),
        .ea       (ea),
        .bus      (bus),
        .ld_mar   (ld_mar),
        .mar_sel  (mar_sel),
        .ld_mdr   (ld_mdr),
        .mem_en   (mem_en),
        .r_w      (r_w),
        .mar      (mar),
        .mdr      (mdr),
        .r        (r),
        .busy     (busy),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .mem_err  (mem_err)
    );

    always @(negedge clk) begin
        if (r === 1'b1) r_cnt <= r_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; pc = '0; ea = '0; bus = '0;
        ld_mar = 0; ld_mdr = 0; mem_en = 0; r_w = 0; mar_sel = 2'b00;
        mem_rdata = '0; mem_ready = 0;
        step();
        step();
        check("rst_mar", mar, 16'h0);
        check("rst_mdr", mdr, 16'h0);
        check("rst_busy", {15'd0, busy}, 16'h0);
        check("rst_req", {15'd0, mem_req}, 16'h0);
        check("rst_r", {15'd0, r}, 16'h0);
        check("rst_we", {15'd0, mem_we}, 16'h0);
        check("rst_err", {15'd0, mem_err}, 16'h0);
        rst = 1'b0;

        // Zero-wait read from PC
        pc = 16'h3000; mar_sel = 2'b00; ld_mar = 1;
        step();
        check("rd_mar", mar, 16'h3000);
        ld_mar = 0;
        mem_en = 1; r_w = 0; mem_ready = 1; mem_rdata = 16'h1234;
        step();
        mem_en = 0;
        check("rd_c1_req", {15'd0, mem_req}, 16'h1);
        check("rd_c1_addr", mem_addr, 16'h3000);
        check("rd_c1_we", {15'd0, mem_we}, 16'h0);
        check("rd_c1_busy", {15'd0, busy}, 16'h1);
        check("rd_c1_r", {15'd0, r}, 16'h0);
        step();
        check("rd_c2_r", {15'd0, r}, 16'h1);
        check("rd_c2_req", {15'd0, mem_req}, 16'h0);
        check("rd_c2_mdr", mdr, 16'h1234);
        check("rd_c2_busy", {15'd0, busy}, 16'h1);
        mem_ready = 0;
        step();
        check("rd_c3_r", {15'd0, r}, 16'h0);
        check("rd_c3_busy", {15'd0, busy}, 16'h0);
        check("rd_rcnt", 16'(r_cnt), 16'd1);

        // Waited write to EA with busy-protection pulses
        mar_sel = 2'b01; ea = 16'hFE06; ld_mar = 1;
        bus = 16'h0041; ld_mdr = 1;
        step();
        ld_mar = 0; ld_mdr = 0;
        check("wr_mar", mar, 16'hFE06);
        check("wr_mdr", mdr, 16'h0041);
        mem_en = 1; r_w = 1;
        step();
        mem_en = 0;
        check("wr_w1_req", {15'd0, mem_req}, 16'h1);
        check("wr_w1_we", {15'd0, mem_we}, 16'h1);
        check("wr_w1_wdata", mem_wdata, 16'h0041);
        mar_sel = 2'b10; bus = 16'hAAAA; ld_mar = 1; ld_mdr = 1;
        mem_en = 1; r_w = 0;
        step();
        ld_mar = 0; ld_mdr = 0; mem_en = 0;
        check("wr_w2_mar", mar, 16'hFE06);
        check("wr_w2_mdr", mdr, 16'h0041);
        check("wr_w2_we", {15'd0, mem_we}, 16'h1);
        check("wr_w2_req", {15'd0, mem_req}, 16'h1);
        step();
        check("wr_w3_req", {15'd0, mem_req}, 16'h1);
        check("wr_w3_addr", mem_addr, 16'hFE06);
        step();
        check("wr_w4_req", {15'd0, mem_req}, 16'h1);
        check("wr_w4_we", {15'd0, mem_we}, 16'h1);
        check("wr_w4_wdata", mem_wdata, 16'h0041);
        check("wr_w4_r", {15'd0, r}, 16'h0);
        mem_ready = 1; mem_rdata = 16'h5555;
        step();
        check("wr_done_r", {15'd0, r}, 16'h1);
        check("wr_done_req", {15'd0, mem_req}, 16'h0);
        check("wr_done_mdr", mdr, 16'h0041);

        // Back-to-back read started in DONE, then aborted by reset
        mem_en = 1; r_w = 0; mem_ready = 0;
        step();
        mem_en = 0;
        check("b2b_req", {15'd0, mem_req}, 16'h1);
        check("b2b_we", {15'd0, mem_we}, 16'h0);
        check("b2b_r", {15'd0, r}, 16'h0);
        check("b2b_busy", {15'd0, busy}, 16'h1);
        check("wr_rcnt", 16'(r_cnt), 16'd2);
        step();
        check("b2b_wait_req", {15'd0, mem_req}, 16'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_req", {15'd0, mem_req}, 16'h0);
        check("abort_busy", {15'd0, busy}, 16'h0);
        check("abort_r", {15'd0, r}, 16'h0);
        check("abort_mar", mar, 16'h0);
        step();
        step();
        check("abort_r2", {15'd0, r}, 16'h0);
        check("abort_rcnt", 16'(r_cnt), 16'd2);

`ifdef MEM_TIMEOUT_EN
        // Read with no ready: 4 REQ cycles, then DONE with error data
        mem_en = 1; r_w = 0; mem_ready = 0;
        step();
        mem_en = 0;
        for (int i = 0; i < 4; i++) begin
            check("to_req", {15'd0, mem_req}, 16'h1);
            check("to_err_lo", {15'd0, mem_err}, 16'h0);
            if (i < 3) step();
        end
        step();
        check("to_r", {15'd0, r}, 16'h1);
        check("to_mdr", mdr, 16'hDEAD);
        check("to_err", {15'd0, mem_err}, 16'h1);
        step();
        step();
        check("to_err_sticky", {15'd0, mem_err}, 16'h1);
        check("to_busy", {15'd0, busy}, 16'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("to_err_clr", {15'd0, mem_err}, 16'h0);
`else
        step();
        check("no_to_err", {15'd0, mem_err}, 16'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
